// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder: WIDTH-bit add/subtract evaluated CHUNK bits per clock,
// with a registered carry between chunks and a start/busy/done handshake.
module chunked_serial_adder #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned N    = WIDTH / CHUNK;
   localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CW1  = CHUNK + 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_part;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;

   logic [CHUNK:0]   w_chunk;
   logic [WIDTH-1:0] w_part_next;
   logic             w_ovf;

   // Operand registers shift right each cycle, so the active chunk is always the low CHUNK bits.
   assign w_chunk = CW1'(r_a[CHUNK-1:0]) + CW1'(r_b[CHUNK-1:0]) + CW1'(r_carry);

   // Chunk results enter at the top of the partial register; after N shifts chunk 0 sits at bit 0.
   assign w_part_next = (r_part >> CHUNK) | (WIDTH'(w_chunk[CHUNK-1:0]) << (WIDTH - CHUNK));

   // On the final chunk the low operand bits hold the original MSBs: equal signs in, different sign out.
   assign w_ovf = (r_a[CHUNK-1] ~^ r_b[CHUNK-1]) & (w_chunk[CHUNK-1] ^ r_a[CHUNK-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_part  <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= sub ? ~b : b;
                  r_carry <= cin ^ sub;
                  r_part  <= '0;
                  r_cnt   <= '0;
                  busy    <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_a     <= r_a >> CHUNK;
               r_b     <= r_b >> CHUNK;
               r_carry <= w_chunk[CHUNK];
               r_part  <= w_part_next;
               r_cnt   <= r_cnt + CW'(1);
               if (r_cnt == LAST) begin
                  sum     <= w_part_next;
                  cout    <= w_chunk[CHUNK];
                  ovf     <= w_ovf;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// tb_chunked_serial_adder: three WIDTH/CHUNK configurations run side by side,
// each with a driver, an expected-result queue and an independent monitor.
module tb_chunked_serial_adder;

   typedef struct {
      logic [31:0] s;
      logic        co;
      logic        ov;
      int          done_cyc;
   } exp_t;

   logic clk = 1'b0;
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   logic [31:0] da [6] = '{32'h0F, 32'hFF, 32'h7F, 32'h05, 32'h80, 32'hFFFF_FFFF};
   logic [31:0] db [6] = '{32'h01, 32'h01, 32'h01, 32'h07, 32'h01, 32'h0};
   logic        dc [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
   logic        ds [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Plain integer arithmetic: unsigned result/carry and signed range check.
   function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, input logic sub);
      exp_t   e;
      longint m, half, ua, ub, c, r, sa, sb, sr;
      m    = longint'(1) <<< w;
      half = m / 2;
      ua   = {32'd0, a} & (m - 1);
      ub   = {32'd0, b} & (m - 1);
      c    = cin ? 1 : 0;
      r    = sub ? (ua - ub - c) : (ua + ub + c);
      e.s  = 32'(((r % m) + m) % m);
      e.co = sub ? (ua >= ub + c) : (r >= m);
      sa   = (ua >= half) ? ua - m : ua;
      sb   = (ub >= half) ? ub - m : ub;
      sr   = sub ? (sa - sb - c) : (sa + sb + c);
      e.ov = (sr < -half) || (sr >= half);
      e.done_cyc = 0;
      return e;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_cfg
      localparam int W = (g == 0) ? 8 : 32;
      localparam int C = (g == 0) ? 4 : ((g == 1) ? 1 : 32);
      localparam int N = W / C;

      logic         rst_n, start, cin, sub, busy, done, cout, ovf;
      logic [W-1:0] a, b, sum;
      exp_t         q [$];
      int           last_acc;
      bit           acc_valid;
      bit           fin;
      logic [W-1:0] held_s;
      logic         held_c, held_o;
      string        tag;

      chunked_serial_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .start (start),
         .a     (a),
         .b     (b),
         .cin   (cin),
         .sub   (sub),
         .busy  (busy),
         .done  (done),
         .sum   (sum),
         .cout  (cout),
         .ovf   (ovf)
      );

      function automatic logic [W-1:0] pick();
         logic [W-1:0] v;
         case ($urandom_range(7))
            0:       v = '0;
            1:       v = '1;
            2:       v = W'(1) << (W - 1);
            3:       v = ~(W'(1) << (W - 1));
            default: v = W'($urandom);
         endcase
         return v;
      endfunction

      // Present one start, queue its expected result, then scramble inputs until the next start slot.
      task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                           input logic ts, input bit junk);
         exp_t e;
         a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
         @(posedge clk); #1;
         e = model(W, 32'(ta), 32'(tb_), tc, ts);
         e.done_cyc = cyc + N;
         q.push_back(e);
         last_acc  = cyc;
         acc_valid = 1'b1;
         for (int k = 0; k < N + 1; k++) begin
            a = W'($urandom); b = W'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            start = junk ? 1'($urandom) : 1'b0;
            @(posedge clk); #1;
         end
      endtask

      initial begin
         tag = $sformatf("w%0d_c%0d", W, C);
         rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
         acc_valid = 1'b0; last_acc = 0; fin = 1'b0;
         repeat (3) @(posedge clk);
         #1 rst_n = 1'b1;

         for (int i = 0; i < 6; i++) issue(W'(da[i]), W'(db[i]), dc[i], ds[i], 1'b1);

         // Abort an operation with an asynchronous reset while it is running.
         a = W'(32'hA5); b = W'(32'h3C); cin = 1'b1; sub = 1'b0; start = 1'b1;
         @(posedge clk); #1;
         last_acc = cyc; acc_valid = 1'b1; start = 1'b0;
         repeat ((N > 1) ? 1 : 0) begin @(posedge clk); #1; end
         #2 rst_n = 1'b0; acc_valid = 1'b0;
         #1;
         chk({tag, " async_rst sum"},  longint'(sum),  0);
         chk({tag, " async_rst busy"}, longint'(busy), 0);
         chk({tag, " async_rst done"}, longint'(done), 0);
         chk({tag, " async_rst cout"}, longint'(cout), 0);
         chk({tag, " async_rst ovf"},  longint'(ovf),  0);
         @(posedge clk); #1 rst_n = 1'b1;
         issue(W'(32'h12), W'(32'h34), 1'b0, 1'b0, 1'b0);

         repeat (1000) begin
            if ($urandom_range(3) == 0) begin
               start = 1'b0;
               repeat ($urandom_range(3)) begin @(posedge clk); #1; end
            end
            issue(pick(), pick(), 1'($urandom), 1'($urandom), 1'($urandom));
         end

         start = 1'b0;
         repeat (N + 4) begin @(posedge clk); #1; end
         chk({tag, " leftover_expected"}, longint'(q.size()), 0);
         fin = 1'b1;
      end

      // Monitor: handshake timing from the accept cycle, results from the queue, held values otherwise.
      initial begin
         exp_t e;
         bit   eb, ed;
         held_s = '0; held_c = 1'b0; held_o = 1'b0;
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               held_s = '0; held_c = 1'b0; held_o = 1'b0;
               chk({tag, " rst sum"},  longint'(sum),  0);
               chk({tag, " rst cout"}, longint'(cout), 0);
               chk({tag, " rst ovf"},  longint'(ovf),  0);
               chk({tag, " rst busy"}, longint'(busy), 0);
               chk({tag, " rst done"}, longint'(done), 0);
            end else begin
               eb = acc_valid && (cyc >= last_acc) && (cyc < last_acc + N);
               ed = acc_valid && (cyc == last_acc + N);
               chk({tag, " busy"}, longint'(busy), longint'(eb));
               chk({tag, " done"}, longint'(done), longint'(ed));
               if (done) begin
                  if (q.size() == 0) begin
                     n_cmp++; n_err++;
                     $display("FAIL %s result: got done with empty queue, want no done", tag);
                  end else begin
                     e = q.pop_front();
                     chk({tag, " sum"},     longint'(sum),  longint'(W'(e.s)));
                     chk({tag, " cout"},    longint'(cout), longint'(e.co));
                     chk({tag, " ovf"},     longint'(ovf),  longint'(e.ov));
                     chk({tag, " latency"}, longint'(cyc),  longint'(e.done_cyc));
                     held_s = W'(e.s); held_c = e.co; held_o = e.ov;
                  end
               end else begin
                  chk({tag, " held sum"},  longint'(sum),  longint'(held_s));
                  chk({tag, " held cout"}, longint'(cout), longint'(held_c));
                  chk({tag, " held ovf"},  longint'(ovf),  longint'(held_o));
               end
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 90000; i++) begin
         if (g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin) break;
         @(posedge clk);
      end
      if (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin)) begin
         n_cmp++; n_err++;
         $display("FAIL timeout: drivers finished got 0, want 1");
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
